// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals: register offsets,
// STATUS bit positions and the UART serializer state encoding.
`timescale 1ns/1ps
package mmio_pkg;

    // Register byte offsets; only bits [3:2] take part in decoding.
    localparam logic [3:0] REG_TXDATA  = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h4;
    localparam logic [3:0] REG_BAUDDIV = 4'h8;

    // STATUS register bit positions.
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    // STATUS write: setting this bit (with byte lane 0 enabled) clears overflow.
    localparam int STAT_OVF_CLR_BIT = 3;

    // UART serializer states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // True when a bus offset selects the given word register (byte bits ignored).
    function automatic logic addr_hits(input logic [3:0] addr, input logic [3:0] reg_off);
        return (addr & 4'hC) == reg_off;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output: dout always presents the oldest
// entry, so a consumer can take the data in the same cycle it pops.
// Pointers carry one extra wrap bit to tell full from empty.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // Full/empty are judged on the current pointers, so a push into a full
    // FIFO is refused even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The array is small; an asynchronous read keeps it in distributed RAM.
    assign dout = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; no reset needed for the data itself.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointer update; wrap bits roll over naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. The core pushes bytes into a small
// FIFO via TXDATA; the serializer drains it onto uart_txd back to back.
// STATUS reports overflow/busy/empty/full; BAUDDIV holds the bit divisor.
`timescale 1ns/1ps
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        uart_txd,
    output logic        tx_empty_irq
);

    localparam logic [15:0] BAUD_DIV_RST = 16'(CLK_HZ / BAUD - 1);

    // Bus decode
    logic        is_store;
    logic        push_req;
    logic        ovf_clr;
    logic        baud_wr;
    logic [31:0] rdata_next;

    // Registers and FIFO interface
    logic        resp_valid_reg;
    logic [31:0] resp_rdata_reg;
    logic        overflow_reg;
    logic        overflow_next;
    logic [15:0] baud_div;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;

    // Serializer
    logic [1:0]  state_reg,   state_next;
    logic [7:0]  shift_reg,   shift_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [15:0] timer_reg,   timer_next;
    logic        txd_reg,     txd_next;
    logic        bit_done;
    logic        busy;

    // Upper data bits and byte lanes no register uses.
    logic unused_bits;
    assign unused_bits = ^{req_wdata[31:16], req_wstrb[3:2]};

    assign is_store = req_valid && req_we;
    assign push_req = is_store && addr_hits(req_addr, REG_TXDATA) && req_wstrb[0];
    assign ovf_clr  = is_store && addr_hits(req_addr, REG_STATUS) && req_wstrb[0]
                      && req_wdata[STAT_OVF_CLR_BIT];
    assign baud_wr  = is_store && addr_hits(req_addr, REG_BAUDDIV);

    assign busy         = (state_reg != ST_IDLE);
    assign tx_empty_irq = fifo_empty && !busy;
    assign resp_valid   = resp_valid_reg;
    assign resp_rdata   = resp_rdata_reg;
    assign uart_txd     = txd_reg;
    assign bit_done     = (timer_reg == 16'd0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (req_wdata[7:0]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // BAUDDIV is split into byte lanes so each write strobe updates its own byte.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_baud_lane
            logic [7:0] lane_reg;
            // One byte of the divisor, reloaded to the reset baud rate.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= BAUD_DIV_RST[gi*8 +: 8];
                end else if (baud_wr && req_wstrb[gi]) begin
                    lane_reg <= req_wdata[gi*8 +: 8];
                end
            end
            assign baud_div[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    // Sticky overflow: a dropped push sets it and beats a same-cycle clear.
    always_comb begin
        overflow_next = overflow_reg;
        if (push_req && fifo_full) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    // Load data reflects register state before this cycle's updates.
    always_comb begin
        rdata_next = 32'd0;
        if (req_valid && !req_we) begin
            if (addr_hits(req_addr, REG_STATUS)) begin
                rdata_next[STAT_OVF]   = overflow_reg;
                rdata_next[STAT_BUSY]  = busy;
                rdata_next[STAT_EMPTY] = fifo_empty;
                rdata_next[STAT_FULL]  = fifo_full;
            end else if (addr_hits(req_addr, REG_BAUDDIV)) begin
                rdata_next[15:0] = baud_div;
            end
        end
    end

    // Bus response and overflow flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
            overflow_reg   <= 1'b0;
        end else begin
            resp_valid_reg <= req_valid;
            resp_rdata_reg <= rdata_next;
            overflow_reg   <= overflow_next;
        end
    end

    // Serializer next-state: each bit lasts baud_div+1 cycles, and the divisor
    // is sampled only when the timer reloads so a running bit is never cut short.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        timer_next   = timer_reg;
        fifo_pop     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_next   = fifo_dout;
                    bit_cnt_next = 3'd0;
                    timer_next   = baud_div;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    timer_next = baud_div;
                    state_next = ST_DATA;
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    timer_next = baud_div;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
            default: begin // ST_STOP: chain straight into the next byte if one waits
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        shift_next   = fifo_dout;
                        bit_cnt_next = 3'd0;
                        timer_next   = baud_div;
                        state_next   = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
        endcase
    end

    // Line level follows the next state, so the registered pin is glitch-free
    // yet lines up with the state register cycle for cycle.
    always_comb begin
        case (state_next)
            ST_START: txd_next = 1'b0;
            ST_DATA:  txd_next = shift_next[0];
            default:  txd_next = 1'b1;
        endcase
    end

    // Serializer state; reset drops any frame in flight and idles the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= 8'd0;
            bit_cnt_reg <= 3'd0;
            timer_reg   <= 16'd0;
            txd_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            timer_reg   <= timer_next;
            txd_reg     <= txd_next;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus transactions plus a line-level model that
// builds the expected txd waveform from bytes and bit lengths.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_addr = 4'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        uart_txd;
    logic        tx_empty_irq;

    mmio_uart_tx #(
        .CLK_HZ     (100_000_000),
        .BAUD       (115200),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .uart_txd     (uart_txd),
        .tx_empty_irq (tx_empty_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Line capture window [cap_from, cap_to), sampled mid-cycle.
    int   cap_from = 0;
    int   cap_to   = 0;
    logic cap_q[$];
    logic exp_q[$];

    always @(negedge clk) begin
        if (cyc >= cap_from && cyc < cap_to) cap_q.push_back(uart_txd);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected line: one 8N1 frame; bits before switch_bit last len_a cycles, others len_b.
    task automatic add_frame(input logic [7:0] b, input int len_a, input int len_b, input int switch_bit);
        for (int k = 0; k < 10; k++) begin
            logic v;
            int   n;
            if (k == 0)      v = 1'b0;
            else if (k == 9) v = 1'b1;
            else             v = b[k-1];
            n = (k < switch_bit) ? len_a : len_b;
            for (int j = 0; j < n; j++) exp_q.push_back(v);
        end
    endtask

    task automatic add_idle(input int n);
        for (int j = 0; j < n; j++) exp_q.push_back(1'b1);
    endtask

    // Wait for the capture window to close, then compare sample by sample.
    task automatic compare_wave(input string tag);
        while (cyc < cap_to) @(negedge clk);
        check_eq({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check_eq($sformatf("%s_s%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
        end
        cap_q.delete();
        exp_q.delete();
        cap_from = 0;
        cap_to   = 0;
    endtask

    // One bus request; caller is at a falling edge, returns at the next one.
    task automatic bus_op(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
        int rc;
        rc        = cyc;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        @(negedge clk);
        check_eq("resp_valid", 32'(resp_valid), 32'd1);
        rdata = resp_rdata;
        if (we) check_eq("store_rdata", resp_rdata, 32'd0);
        $display("[TB] cyc %0d %s addr=0x%0h wdata=0x%08h wstrb=%b rdata=0x%08h",
                 rc, we ? "ST" : "LD", addr, wdata, wstrb, rdata);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 4'd0;
        req_wdata = 32'd0;
        req_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] dummy;
        bus_op(1'b1, addr, wdata, wstrb, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        bus_op(1'b0, addr, $urandom, 4'hF, r);
        check_eq(tag, r, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int          c;
        int          s;
        int          kind;
        int          ridx;
        logic [15:0] baud_m;
        logic [31:0] d;
        logic [3:0]  st;
        logic [3:0]  a;
        logic [31:0] e;
        logic [7:0]  ovf_bytes [10];
        logic [7:0]  b;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        check_eq("rst_txd", 32'(uart_txd), 32'd1);
        check_eq("rst_irq", 32'(tx_empty_irq), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd_chk("rst_status", 4'h4, 32'h2);
        rd_chk("rst_bauddiv", 4'h8, 32'd867);

        // ---------------- random bus traffic, no pushes ----------------
        baud_m = 16'd867;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 5));
            d    = $urandom;
            st   = 4'($urandom_range(0, 15));
            case (kind)
                0: begin
                    ridx = int'($urandom_range(0, 3));
                    a = {2'(ridx), 2'($urandom_range(0, 3))};
                    if (ridx == 1)      e = 32'h2;
                    else if (ridx == 2) e = {16'd0, baud_m};
                    else                e = 32'd0;
                    rd_chk("rand_load", a, e);
                end
                1: begin
                    wr({2'b10, 2'($urandom_range(0, 3))}, d, st);
                    if (st[0]) baud_m[7:0]  = d[7:0];
                    if (st[1]) baud_m[15:8] = d[15:8];
                end
                2: wr({2'b11, 2'($urandom_range(0, 3))}, d, st);
                3: wr(4'h0, d, {st[3:1], 1'b0});
                4: wr(4'h4, d, st);
                default: rd_chk("rand_status", 4'h4, 32'h2);
            endcase
        end
        rd_chk("rand_bauddiv_final", 4'h8, {16'd0, baud_m});
        rd_chk("rand_status_final", 4'h4, 32'h2);
        check_eq("rand_txd_idle", 32'(uart_txd), 32'd1);
        check_eq("rand_irq", 32'(tx_empty_irq), 32'd1);
        @(negedge clk);
        check_eq("resp_valid_idle", 32'(resp_valid), 32'd0);
        wr(4'h8, 32'hABCD_0003, 4'hF);
        rd_chk("baud_upper_zero", 4'h8, 32'd3);

        // ---------------- single byte 0xA5 at divisor 3 ----------------
        c = cyc;
        cap_from = c + 1;
        add_idle(1);
        add_frame(8'hA5, 4, 4, 10);
        add_idle(4);
        cap_to = cap_from + exp_q.size();
        wr(4'h0, 32'h0000_00A5, 4'b0001);
        compare_wave("single");
        check_eq("single_irq_after", 32'(tx_empty_irq), 32'd1);

        // ---------------- back-to-back 0x01,0x02,0x03 ----------------
        c = cyc;
        s = c + 2;
        cap_from = s;
        add_frame(8'h01, 4, 4, 10);
        add_frame(8'h02, 4, 4, 10);
        add_frame(8'h03, 4, 4, 10);
        add_idle(4);
        cap_to = cap_from + exp_q.size();
        wr(4'h0, 32'h01, 4'b0001);
        wr(4'h0, 32'h02, 4'b0001);
        wr(4'h0, 32'h03, 4'b0001);
        rd_chk("b2b_status_busy", 4'h4, 32'h4);
        while (cyc < s + 119) @(negedge clk);
        check_eq("b2b_irq_last_stop", 32'(tx_empty_irq), 32'd0);
        @(negedge clk);
        check_eq("b2b_irq_rise", 32'(tx_empty_irq), 32'd1);
        compare_wave("b2b");

        // ---------------- baud change during data bit 3 ----------------
        b = 8'($urandom);
        c = cyc;
        s = c + 2;
        cap_from = s;
        add_frame(b, 4, 8, 5);
        add_idle(4);
        cap_to = cap_from + exp_q.size();
        wr(4'h0, {24'd0, b}, 4'b0001);
        while (cyc < s + 16) @(negedge clk);
        wr(4'h8, 32'd7, 4'b0011);
        compare_wave("baudchg");
        wr(4'h8, 32'd100, 4'b0011);

        // ---------------- overflow at divisor 100 ----------------
        for (int i = 0; i < 10; i++) ovf_bytes[i] = 8'($urandom);
        c = cyc;
        s = c + 2;
        cap_from = s;
        for (int i = 0; i < 9; i++) add_frame(ovf_bytes[i], 101, 101, 10);
        add_idle(2);
        cap_to = cap_from + exp_q.size();
        for (int i = 0; i < 10; i++) wr(4'h0, {24'd0, ovf_bytes[i]}, 4'b0001);
        rd_chk("ovf_status_set", 4'h4, 32'hD);
        wr(4'h4, 32'h8, 4'b0010);
        rd_chk("ovf_clear_needs_lane0", 4'h4, 32'hD);
        wr(4'h4, 32'h8, 4'b0001);
        rd_chk("ovf_status_cleared", 4'h4, 32'h5);
        while (cyc < s + 9089) @(negedge clk);
        check_eq("ovf_irq_last_stop", 32'(tx_empty_irq), 32'd0);
        @(negedge clk);
        check_eq("ovf_irq_rise", 32'(tx_empty_irq), 32'd1);
        compare_wave("ovf");

        // ---------------- reset mid-frame ----------------
        wr(4'h8, 32'd3, 4'b0011);
        c = cyc;
        wr(4'h0, 32'h3C, 4'b0001);
        while (cyc < c + 3) @(negedge clk);
        check_eq("midrst_txd_start", 32'(uart_txd), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_txd_now", 32'(uart_txd), 32'd1);
        check_eq("midrst_irq_now", 32'(tx_empty_irq), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_chk("midrst_status", 4'h4, 32'h2);
        rd_chk("midrst_bauddiv", 4'h8, 32'd867);
        repeat (10) @(negedge clk);
        check_eq("midrst_txd_stays", 32'(uart_txd), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
